spi_prot_trig: RTL and testbench

Parametrised SPI protocol trigger for the logic-analyzer digital core. It watches asynchronous SS_n/SCLK/MOSI channel inputs, deserialises a frame of programmable length and selectable sampling edge, and compares it against a masked match value. On a match it raises a one-cycle trigger to the capture/trigger logic. It generalises the fixed 8/16-bit SPI trigger to any frame width up to DATA_W and adds frame-error reporting.

---
 rtl/spi_prot_trig_if.sv | 17 +
 rtl/spi_prot_trig.sv | 180 ++++++++++++++++++
 tb/tb_spi_prot_trig.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_prot_trig_if.sv
// -----------------------------------------------------------------------------
// spi_prot_trig_if
// Groups the three SPI channel wires watched by the protocol trigger.
//   SS_n : SPI select, idle high
//   SCLK : SPI clock
//   MOSI : SPI data, master to slave
// master modport drives the wires (pattern source or bench).
// slave modport observes them (spi_prot_trig).
// -----------------------------------------------------------------------------
interface spi_prot_trig_if;
   logic SS_n;
   logic SCLK;
   logic MOSI;

   modport master (output SS_n, SCLK, MOSI);
   modport slave  (input  SS_n, SCLK, MOSI);
endinterface

// File: rtl/spi_prot_trig.sv
// -----------------------------------------------------------------------------
// spi_prot_trig
// SPI protocol trigger for the logic-analyzer core. It synchronises the
// asynchronous SS_n/SCLK/MOSI channel inputs and deserialises one frame of
// programmable length on the selected SCLK edge. At the end of the frame it
// compares the frame against a masked match value and raises a one-cycle
// trigger when they agree. A frame that ends with the wrong bit count is
// reported on frame_err.
//
// Optional feature: define SPI_LSB_FIRST_EN to add the lsb_first port. When
// lsb_first is 1, the i-th received bit lands at rx_data[i].
//
// Ports
//   clk        system clock (single domain)
//   rst_n      asynchronous active-low reset
//   spi        SS_n / SCLK / MOSI channel inputs (asynchronous)
//   nbits      frame length; 0 or > DATA_W selects DATA_W
//   edge_pos   1: sample MOSI on SCLK rise, 0: on SCLK fall
//   armed      trigger enable
//   match      compare value, right-aligned
//   mask       1 = don't-care bit
//   lsb_first  (SPI_LSB_FIRST_EN only) LSB-first bit order, latched at frame start
//   rx_data    last complete frame, right-aligned, upper bits 0
//   rx_vld     one-cycle pulse, rx_data updated
//   trig       one-cycle pulse on masked match
//   frame_err  one-cycle pulse, frame ended with a wrong bit count
// -----------------------------------------------------------------------------
module spi_prot_trig #(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 3,
   parameter int NB_W        = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_prot_trig_if.slave    spi,
   input  logic [NB_W-1:0]   nbits,
   input  logic              edge_pos,
   input  logic              armed,
   input  logic [DATA_W-1:0] match,
   input  logic [DATA_W-1:0] mask,
`ifdef SPI_LSB_FIRST_EN
   input  logic              lsb_first,
`endif
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_vld,
   output logic              trig,
   output logic              frame_err
);

   // Synchroniser stages plus one extra flop for edge detection.
   localparam int SL = SYNC_STAGES + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RX   = 1'b1;

   function automatic logic [NB_W-1:0] eff_nbits(input logic [NB_W-1:0] n);
      if ((n == '0) || (n > NB_W'(DATA_W)))
         eff_nbits = NB_W'(DATA_W);
      else
         eff_nbits = n;
   endfunction

   function automatic logic [DATA_W-1:0] len_mask(input logic [NB_W-1:0] n);
      for (int i = 0; i < DATA_W; i++)
         len_mask[i] = (i < int'(n));
   endfunction

   logic [SL-1:0]     ss_sync, sclk_sync, mosi_sync;
   logic [SL-1:0]     qual;
   logic              ss_fall, ss_rise, sclk_edge, mosi_bit, lsb_in;
   logic [0:0]        state;
   logic [DATA_W-1:0] shift_q, shift_nx;
   logic [NB_W-1:0]   cnt_q, nb_q;
   logic              lsb_q;
   logic              vld_p0, ok_p0, hit_p0;
   logic [DATA_W-1:0] shift_p0;

`ifdef SPI_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   // ---- input synchronisers ----
   // qual fills with ones after reset. An edge is trusted only once the oldest
   // flop holds a real sample, so the reset value of SS_n cannot fake a fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         qual      <= '0;
      end else begin
         ss_sync   <= {ss_sync[SL-2:0], spi.SS_n};
         sclk_sync <= {sclk_sync[SL-2:0], spi.SCLK};
         mosi_sync <= {mosi_sync[SL-2:0], spi.MOSI};
         qual      <= {qual[SL-2:0], 1'b1};
      end
   end

   assign ss_fall   = qual[SL-1] &  ss_sync[SL-1] & ~ss_sync[SL-2];
   assign ss_rise   = qual[SL-1] & ~ss_sync[SL-1] &  ss_sync[SL-2];
   assign sclk_edge = qual[SL-1] & (edge_pos ? (~sclk_sync[SL-1] &  sclk_sync[SL-2])
                                             : ( sclk_sync[SL-1] & ~sclk_sync[SL-2]));
   // MOSI from the same stage as the older SCLK sample: the value held just before the edge.
   assign mosi_bit  = mosi_sync[SL-1];

   always_comb begin
      shift_nx = {shift_q[DATA_W-2:0], mosi_bit};
      if (lsb_q)
         shift_nx = shift_q | (DATA_W'(mosi_bit) << cnt_q);
   end

   // ---- frame FSM / stage p0: frame end captured, match evaluated ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         nb_q    <= '0;
         lsb_q   <= 1'b0;
         vld_p0  <= 1'b0;
         ok_p0   <= 1'b0;
         hit_p0  <= 1'b0;
      end else begin
         vld_p0 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ss_fall) begin
                  state   <= ST_RX;
                  shift_q <= '0;
                  cnt_q   <= '0;
                  nb_q    <= eff_nbits(nbits);
                  lsb_q   <= lsb_in;
               end
            end
            ST_RX: begin
               // SS_n rise has priority over a coincident SCLK edge.
               if (ss_rise) begin
                  state  <= ST_IDLE;
                  vld_p0 <= 1'b1;
                  ok_p0  <= (cnt_q == nb_q);
                  hit_p0 <= armed && (((shift_q ^ match) & ~mask & len_mask(nb_q)) == '0);
               end else if (sclk_edge) begin
                  if (cnt_q < nb_q) begin
                     shift_q <= shift_nx;
                     cnt_q   <= cnt_q + 1'b1;
                  end else begin
                     // Overrun: count parks one past nbits so the frame end flags it.
                     cnt_q   <= nb_q + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if ((state == ST_RX) && ss_rise)
         shift_p0 <= shift_q;
   end

   // ---- stage p1: registered result pulses ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_vld    <= 1'b0;
         trig      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_vld    <= vld_p0 & ok_p0;
         trig      <= vld_p0 & ok_p0 & hit_p0;
         frame_err <= vld_p0 & ~ok_p0;
         if (vld_p0 && ok_p0)
            rx_data <= shift_p0;
      end
   end

endmodule

// File: tb/tb_spi_prot_trig.sv
module tb_spi_prot_trig;

   localparam int DATA_W      = 16;
   localparam int SYNC_STAGES = 3;
   localparam int NB_W        = $clog2(DATA_W) + 1;
   localparam int HALF        = 6;   // SCLK half period in clk cycles

   logic              clk;
   logic              rst_n;
   logic [NB_W-1:0]   nbits;
   logic              edge_pos;
   logic              armed;
   logic [DATA_W-1:0] match;
   logic [DATA_W-1:0] mask;
`ifdef SPI_LSB_FIRST_EN
   logic              lsb_first;
`endif
   logic [DATA_W-1:0] rx_data;
   logic              rx_vld;
   logic              trig;
   logic              frame_err;

   spi_prot_trig_if spi_bus();

   spi_prot_trig #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi       (spi_bus.slave),
      .nbits     (nbits),
      .edge_pos  (edge_pos),
      .armed     (armed),
      .match     (match),
      .mask      (mask),
`ifdef SPI_LSB_FIRST_EN
      .lsb_first (lsb_first),
`endif
      .rx_data   (rx_data),
      .rx_vld    (rx_vld),
      .trig      (trig),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Pulse counters, cumulative; scenarios take differences around a frame.
   int mon_vld  = 0;
   int mon_trig = 0;
   int mon_err  = 0;
   int mon_bad  = 0;   // trig without rx_vld in the same cycle

   always @(negedge clk) begin
      if (rx_vld)           mon_vld++;
      if (trig)             mon_trig++;
      if (frame_err)        mon_err++;
      if (trig && !rx_vld)  mon_bad++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ss_fall();
      spi_bus.MOSI = 1'b0;
      spi_bus.SCLK = 1'b0;
      wait_clk(HALF);
      spi_bus.SS_n = 1'b0;
      wait_clk(HALF);
   endtask

   // Sends val[n-1:0], first bit on the wire is val[n-1].
   task automatic send_bits(input logic [31:0] val, input int n, input bit launch_rise);
      for (int i = n - 1; i >= 0; i--) begin
         if (launch_rise) begin
            spi_bus.SCLK = 1'b1;
            spi_bus.MOSI = val[i];
            wait_clk(HALF);
            spi_bus.SCLK = 1'b0;
            wait_clk(HALF);
         end else begin
            spi_bus.MOSI = val[i];
            wait_clk(HALF);
            spi_bus.SCLK = 1'b1;
            wait_clk(HALF);
            spi_bus.SCLK = 1'b0;
         end
      end
   endtask

   // Raises SS_n on a falling clk edge and reports how many rising edges later
   // the first result pulse was seen (-1 if none within the window).
   task automatic ss_rise(output int lat);
      wait_clk(HALF);
      spi_bus.SS_n = 1'b1;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (lat < 0 && (rx_vld || frame_err)) lat = k;
      end
      wait_clk(2);
   endtask

   task automatic do_frame(input logic [31:0] val, input int n, input bit launch_rise,
                           output int dv, output int dt, output int de, output int db,
                           output int lat);
      int v0, t0, e0, b0;
      v0 = mon_vld; t0 = mon_trig; e0 = mon_err; b0 = mon_bad;
      ss_fall();
      send_bits(val, n, launch_rise);
      ss_rise(lat);
      dv = mon_vld - v0; dt = mon_trig - t0; de = mon_err - e0; db = mon_bad - b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      spi_bus.SS_n = 1'b1; spi_bus.SCLK = 1'b0; spi_bus.MOSI = 1'b0;
      nbits = '0; edge_pos = 1'b1; armed = 1'b0; match = '0; mask = '0;
`ifdef SPI_LSB_FIRST_EN
      lsb_first = 1'b0;
`endif
      wait_clk(3);
      n_tests++; if (rx_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rx_data: got %h want 0000", rx_data); end
      n_tests++; if (rx_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rx_vld: got %b want 0", rx_vld); end
      n_tests++; if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", trig); end
      n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      rst_n = 1'b1;
      wait_clk(SYNC_STAGES + 4);
      n_tests++; if ({rx_vld, trig, frame_err} !== 3'b000) begin n_fail++; $display("FAIL reset_idle_pulses: got %b want 000", {rx_vld, trig, frame_err}); end
   endtask

   task automatic test_basic();
      int dv, dt, de, db, lat;
      nbits = 5'd16; edge_pos = 1'b1; armed = 1'b1; match = 16'hF0F1; mask = '0;
      do_frame(32'hF0F1, 16, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (rx_data !== 16'hF0F1) begin n_fail++; $display("FAIL basic_rx_data: got %h want f0f1", rx_data); end
      n_tests++; if (dv !== 1) begin n_fail++; $display("FAIL basic_rx_vld_cycles: got %0d want 1", dv); end
      n_tests++; if (dt !== 1) begin n_fail++; $display("FAIL basic_trig_cycles: got %0d want 1", dt); end
      n_tests++; if (db !== 0) begin n_fail++; $display("FAIL basic_trig_without_vld: got %0d want 0", db); end
      n_tests++; if (de !== 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d want 0", de); end
      n_tests++; if (lat !== SYNC_STAGES + 2) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, SYNC_STAGES + 2); end
   endtask

   task automatic test_mask();
      int dv, dt, de, db, lat;
      match = 16'hEECC; mask = 16'h100F;
      do_frame(32'hFEC8, 16, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (dt !== 1) begin n_fail++; $display("FAIL mask_hit_trig: got %0d want 1", dt); end
      n_tests++; if (rx_data !== 16'hFEC8) begin n_fail++; $display("FAIL mask_hit_rx_data: got %h want fec8", rx_data); end
      do_frame(32'hFFC8, 16, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (dv !== 1) begin n_fail++; $display("FAIL mask_miss_rx_vld: got %0d want 1", dv); end
      n_tests++; if (dt !== 0) begin n_fail++; $display("FAIL mask_miss_trig: got %0d want 0", dt); end
   endtask

   task automatic test_length();
      int dv, dt, de, db, lat, v0;
      nbits = 5'd8;
      do_frame(32'hA5, 8, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (rx_data !== 16'h00A5) begin n_fail++; $display("FAIL len8_rx_data: got %h want 00a5", rx_data); end
      n_tests++; if (dv !== 1) begin n_fail++; $display("FAIL len8_rx_vld: got %0d want 1", dv); end
      do_frame(32'h1FF, 9, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (de !== 1) begin n_fail++; $display("FAIL len9_frame_err: got %0d want 1", de); end
      n_tests++; if (dv !== 0) begin n_fail++; $display("FAIL len9_rx_vld: got %0d want 0", dv); end
      n_tests++; if (rx_data !== 16'h00A5) begin n_fail++; $display("FAIL len9_rx_data_held: got %h want 00a5", rx_data); end
      n_tests++; if (lat !== SYNC_STAGES + 2) begin n_fail++; $display("FAIL len9_err_latency: got %0d want %0d", lat, SYNC_STAGES + 2); end
      do_frame(32'h15, 5, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (de !== 1) begin n_fail++; $display("FAIL len5_frame_err: got %0d want 1", de); end
      // nbits changing mid-frame must not affect the latched length.
      v0 = mon_vld;
      ss_fall();
      nbits = 5'd16;
      send_bits(32'h3C, 8, 1'b0);
      ss_rise(lat);
      n_tests++; if ((mon_vld - v0) !== 1 || rx_data !== 16'h003C) begin n_fail++; $display("FAIL len_latched: got vld=%0d data=%h want vld=1 data=003c", mon_vld - v0, rx_data); end
      // nbits=0 selects the full DATA_W frame.
      nbits = 5'd0;
      do_frame(32'h8001, 16, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (dv !== 1 || rx_data !== 16'h8001) begin n_fail++; $display("FAIL len0_full: got vld=%0d data=%h want vld=1 data=8001", dv, rx_data); end
   endtask

   task automatic test_edge();
      int dv, dt, de, db, lat;
      nbits = 5'd16; edge_pos = 1'b0;
      do_frame(32'h1234, 16, 1'b1, dv, dt, de, db, lat);
      n_tests++; if (dv !== 1 || rx_data !== 16'h1234) begin n_fail++; $display("FAIL edge_fall_rx: got vld=%0d data=%h want vld=1 data=1234", dv, rx_data); end
      // Sampling on the launching edge captures the previous wire bit (idle 0 first).
      edge_pos = 1'b1;
      do_frame(32'h1234, 16, 1'b1, dv, dt, de, db, lat);
      n_tests++; if (rx_data === 16'h1234) begin n_fail++; $display("FAIL edge_wrong_differs: got %h want not 1234", rx_data); end
      n_tests++; if (rx_data !== 16'h091A) begin n_fail++; $display("FAIL edge_wrong_value: got %h want 091a", rx_data); end
   endtask

   task automatic test_armed_reset();
      int dv, dt, de, db, lat, v0, e0;
      nbits = 5'd16; edge_pos = 1'b1; armed = 1'b0; match = 16'hF0F1; mask = '0;
      do_frame(32'hF0F1, 16, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (dv !== 1) begin n_fail++; $display("FAIL disarmed_rx_vld: got %0d want 1", dv); end
      n_tests++; if (dt !== 0) begin n_fail++; $display("FAIL disarmed_trig: got %0d want 0", dt); end
      armed = 1'b1;
      ss_fall();
      send_bits(32'hF0F1 >> 11, 5, 1'b0);
      rst_n = 1'b0;
      wait_clk(3);
      n_tests++; if ({rx_data, rx_vld, trig, frame_err} !== 19'h0) begin n_fail++; $display("FAIL midreset_outputs: got data=%h vld=%b trig=%b err=%b want all 0", rx_data, rx_vld, trig, frame_err); end
      rst_n = 1'b1;
      // Rest of the aborted frame: SS_n never fell after reset, so nothing happens.
      v0 = mon_vld; e0 = mon_err;
      send_bits(32'hF0F1, 11, 1'b0);
      ss_rise(lat);
      n_tests++; if ((mon_vld - v0) !== 0 || (mon_err - e0) !== 0) begin n_fail++; $display("FAIL midreset_stale_frame: got vld=%0d err=%0d want 0 0", mon_vld - v0, mon_err - e0); end
      do_frame(32'hF0F1, 16, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (dt !== 1 || dv !== 1 || rx_data !== 16'hF0F1) begin n_fail++; $display("FAIL after_reset_trig: got trig=%0d vld=%0d data=%h want 1 1 f0f1", dt, dv, rx_data); end
   endtask

   task automatic test_random();
      int dv, dt, de, db, lat, nb, eff, n;
      logic [31:0] wire_v, lm;
      logic [DATA_W-1:0] model_rx, exp_rx;
      int exp_v, exp_t, exp_e;
      rst_n = 1'b0;
      wait_clk(2);
      rst_n = 1'b1;
      model_rx = '0;
      for (int it = 0; it < 40; it++) begin
         nb  = $urandom_range(0, 20);
         eff = (nb == 0 || nb > DATA_W) ? DATA_W : nb;
         case ($urandom_range(0, 3))
            0:       n = eff - 1;
            1:       n = eff + 1;
            default: n = eff;
         endcase
         wire_v   = $urandom;
         mask     = DATA_W'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 1) == 1)
            match = DATA_W'(wire_v) ^ (DATA_W'($urandom) & mask);
         else
            match = DATA_W'($urandom);
         armed    = 1'($urandom_range(0, 1));
         edge_pos = 1'($urandom_range(0, 1));
         nbits    = NB_W'(nb);
         do_frame(wire_v, n, !edge_pos, dv, dt, de, db, lat);
         // Reference: a frame of exactly eff bits is the low eff wire bits.
         lm = (32'h1 << eff) - 32'h1;
         if (n == eff) begin
            exp_rx   = DATA_W'(wire_v & lm);
            exp_v    = 1;
            exp_e    = 0;
            exp_t    = (armed && (((exp_rx ^ match) & ~mask & DATA_W'(lm)) == '0)) ? 1 : 0;
            model_rx = exp_rx;
         end else begin
            exp_v = 0; exp_t = 0; exp_e = 1;
         end
         n_tests++; if (dv !== exp_v) begin n_fail++; $display("FAIL rand%0d_rx_vld: got %0d want %0d (nbits=%0d bits=%0d)", it, dv, exp_v, nb, n); end
         n_tests++; if (dt !== exp_t) begin n_fail++; $display("FAIL rand%0d_trig: got %0d want %0d", it, dt, exp_t); end
         n_tests++; if (de !== exp_e) begin n_fail++; $display("FAIL rand%0d_frame_err: got %0d want %0d", it, de, exp_e); end
         n_tests++; if (db !== 0) begin n_fail++; $display("FAIL rand%0d_trig_without_vld: got %0d want 0", it, db); end
         n_tests++; if (rx_data !== model_rx) begin n_fail++; $display("FAIL rand%0d_rx_data: got %h want %h", it, rx_data, model_rx); end
      end
   endtask

`ifdef SPI_LSB_FIRST_EN
   task automatic test_lsb_first();
      int dv, dt, de, db, lat;
      nbits = 5'd8; edge_pos = 1'b1;
      lsb_first = 1'b1;
      do_frame(32'h80, 8, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (rx_data !== 16'h0001) begin n_fail++; $display("FAIL lsb_first_1: got %h want 0001", rx_data); end
      lsb_first = 1'b0;
      do_frame(32'h80, 8, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (rx_data !== 16'h0080) begin n_fail++; $display("FAIL lsb_first_0: got %h want 0080", rx_data); end
      lsb_first = 1'b1;
      do_frame(32'hB1, 8, 1'b0, dv, dt, de, db, lat);
      n_tests++; if (rx_data !== 16'h008D) begin n_fail++; $display("FAIL lsb_first_b1: got %h want 008d", rx_data); end
      lsb_first = 1'b0;
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      spi_bus.SS_n = 1'b1;
      spi_bus.SCLK = 1'b0;
      spi_bus.MOSI = 1'b0;
      test_reset();
      test_basic();
      test_mask();
      test_length();
      test_edge();
      test_armed_reset();
`ifdef SPI_LSB_FIRST_EN
      test_lsb_first();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
